abp_msg_channel: RTL and testbench

- Bounded, lossy, in-order message channel between the ABP sender's message output and the receiver's message input.
- Replaces the direct wire so the frame-loss and corruption the protocol must survive become explicit, controllable and countable.
- Loss and corruption are driven by environment oracle pins, which a formal harness leaves free, so the block stays synthesizable.

---
 rtl/abp_pkg.sv | 25 ++
 rtl/abp_sat_counter.sv | 19 +
 rtl/abp_msg_channel.sv | 101 ++++++++++
 tb/tb_abp_msg_channel.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/abp_pkg.sv
// Shared ABP message/ack encodings, used by the message and ack-direction channels.
package abp_pkg;

  typedef enum logic [2:0] {
    DATA00 = 3'd0,
    DATA01 = 3'd1,
    DATA10 = 3'd2,
    DATA11 = 3'd3,
    DERR   = 3'd4
  } data_status_t;

  typedef enum logic [1:0] {
    AM0  = 2'd0,
    AM1  = 2'd1,
    AERR = 2'd2
  } ack_status_t;

  typedef enum logic {
    BOOL_F = 1'b0,
    BOOL_T = 1'b1
  } bool_status_t;

  localparam logic [2:0] ABP_DERR = 3'(DERR);

endpackage

// File: rtl/abp_sat_counter.sv
// Saturating up-counter used for the channel loss/corruption statistics.
module abp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/abp_msg_channel.sv
// Bounded, lossy, in-order ABP message channel with oracle-driven drop/corrupt.
// Optional frame duplication on delivery is enabled with `define ABP_CHAN_DUP_EN.
module abp_msg_channel
  import abp_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int CNT_W = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [2:0]       in_msg,
  output logic             in_ready,
  input  logic             drop,
  input  logic             corrupt,
  output logic             out_valid,
  output logic [2:0]       out_msg,
  input  logic             out_ready,
  input  logic             dup,
  output logic [CW-1:0]    count,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] corrupt_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic       accept;
  logic       store;
  logic       pop;
  logic       advance;
  logic [2:0] wr_data;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_msg   = out_valid ? mem[rd_ptr] : ABP_DERR;
  assign count     = count_q;

  assign accept  = in_valid && in_ready;
  assign store   = accept && !drop;
  assign pop     = out_valid && out_ready;
  assign wr_data = (corrupt || (in_msg > ABP_DERR)) ? ABP_DERR : in_msg;

`ifdef ABP_CHAN_DUP_EN
  // A duplicating pop delivers the head but leaves it in place.
  assign advance = pop && !dup;
`else
  logic unused_dup;
  assign unused_dup = dup;
  assign advance    = pop;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ABP_DERR;
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (advance) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (store && !advance) begin
        count_q <= count_q + 1'b1;
      end else if (!store && advance) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  abp_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept && drop),
    .value   (drop_cnt)
  );

  abp_sat_counter #(.W(CNT_W)) u_corrupt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept && !drop && corrupt),
    .value   (corrupt_cnt)
  );

endmodule

// File: tb/tb_abp_msg_channel.sv
// Self-checking bench for abp_msg_channel: vector table, corner sequences, random vs queue model.
module tb_abp_msg_channel;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic [2:0]       in_msg;
  logic             in_ready;
  logic             drop;
  logic             corrupt;
  logic             out_valid;
  logic [2:0]       out_msg;
  logic             out_ready;
  logic             dup;
  logic [1:0]       count;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] corrupt_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  abp_msg_channel #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_msg      (in_msg),
    .in_ready    (in_ready),
    .drop        (drop),
    .corrupt     (corrupt),
    .out_valid   (out_valid),
    .out_msg     (out_msg),
    .out_ready   (out_ready),
    .dup         (dup),
    .count       (count),
    .drop_cnt    (drop_cnt),
    .corrupt_cnt (corrupt_cnt)
  );

  typedef struct {
    logic       v;
    logic [2:0] m;
    logic       d;
    logic       c;
    logic       r;
    int         e_valid;
    int         e_msg;
    int         e_ready;
    int         e_count;
    int         e_drop;
    int         e_corr;
  } vec_t;

  vec_t vecs[14];

  // Behavioural reference: a bounded queue plus two saturating tallies.
  logic [2:0] mq[$];
  int         m_drop;
  int         m_corr;

  int         delivered[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_corr = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] m, input logic d,
                            input logic c, input logic r, input logic u);
    bit acc;
    bit popd;
    bit keep;
    acc  = v && (mq.size() != DEPTH);
    popd = (mq.size() != 0) && r;
`ifdef ABP_CHAN_DUP_EN
    keep = u;
`else
    keep = 1'b0;
`endif
    if (popd && !keep) void'(mq.pop_front());
    if (acc) begin
      if (d) begin
        if (m_drop < CMAX) m_drop++;
      end else begin
        mq.push_back((c || m > 3'd4) ? 3'd4 : m);
        if (c && m_corr < CMAX) m_corr++;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".out_valid"},   int'(out_valid),   (mq.size() != 0) ? 1 : 0);
    chk({tag, ".out_msg"},     int'(out_msg),     (mq.size() != 0) ? int'(mq[0]) : 4);
    chk({tag, ".in_ready"},    int'(in_ready),    (mq.size() != DEPTH) ? 1 : 0);
    chk({tag, ".count"},       int'(count),       mq.size());
    chk({tag, ".drop_cnt"},    int'(drop_cnt),    m_drop);
    chk({tag, ".corrupt_cnt"}, int'(corrupt_cnt), m_corr);
  endtask

  // Inputs are applied 1ns after an edge; pops are logged just before the next edge.
  task automatic step(input logic v, input logic [2:0] m, input logic d,
                      input logic c, input logic r, input logic u);
    in_valid  = v;
    in_msg    = m;
    drop      = d;
    corrupt   = c;
    out_ready = r;
    dup       = u;
    #3;
    if (out_valid && out_ready) delivered.push_back(int'(out_msg));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n_two;
    int exp_deliv;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    drop      = 1'b0;
    corrupt   = 1'b0;
    out_ready = 1'b0;
    dup       = 1'b0;

    //         v  m     d  c  r  valid msg rdy cnt drp cor
    vecs[0]  = '{0, 3'd0, 0, 0, 0, 0, 4, 1, 0, 0, 0};
    vecs[1]  = '{1, 3'd2, 0, 0, 0, 1, 2, 1, 1, 0, 0};
    vecs[2]  = '{1, 3'd1, 0, 0, 0, 1, 2, 0, 2, 0, 0};
    vecs[3]  = '{1, 3'd3, 0, 0, 0, 1, 2, 0, 2, 0, 0};
    vecs[4]  = '{0, 3'd0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    vecs[5]  = '{0, 3'd0, 0, 0, 1, 0, 4, 1, 0, 0, 0};
    vecs[6]  = '{1, 3'd0, 1, 1, 0, 0, 4, 1, 0, 1, 0};
    vecs[7]  = '{1, 3'd3, 0, 1, 0, 1, 4, 1, 1, 1, 1};
    vecs[8]  = '{1, 3'd2, 0, 0, 0, 1, 4, 0, 2, 1, 1};
    vecs[9]  = '{1, 3'd1, 0, 0, 1, 1, 2, 1, 1, 1, 1};
    vecs[10] = '{1, 3'd7, 0, 0, 0, 1, 2, 0, 2, 1, 1};
    vecs[11] = '{0, 3'd0, 0, 0, 1, 1, 4, 1, 1, 1, 1};
    vecs[12] = '{0, 3'd0, 0, 0, 1, 0, 4, 1, 0, 1, 1};
    vecs[13] = '{0, 3'd5, 1, 1, 0, 0, 4, 1, 0, 1, 1};

    #1;
    chk("reset.out_valid", int'(out_valid), 0);
    chk("reset.out_msg",   int'(out_msg),   4);
    chk("reset.in_ready",  int'(in_ready),  1);
    chk("reset.count",     int'(count),     0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    delivered.delete();
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].v, vecs[i].m, vecs[i].d, vecs[i].c, vecs[i].r, 1'b0);
      chk($sformatf("vec%0d.out_valid", i),   int'(out_valid),   vecs[i].e_valid);
      chk($sformatf("vec%0d.out_msg", i),     int'(out_msg),     vecs[i].e_msg);
      chk($sformatf("vec%0d.in_ready", i),    int'(in_ready),    vecs[i].e_ready);
      chk($sformatf("vec%0d.count", i),       int'(count),       vecs[i].e_count);
      chk($sformatf("vec%0d.drop_cnt", i),    int'(drop_cnt),    vecs[i].e_drop);
      chk($sformatf("vec%0d.corrupt_cnt", i), int'(corrupt_cnt), vecs[i].e_corr);
    end
    chk("order.n_delivered", delivered.size(), 5);
    if (delivered.size() == 5) begin
      chk("order.first",  delivered[0], 2);
      chk("order.second", delivered[1], 1);
      chk("order.third",  delivered[2], 4);
      chk("order.fourth", delivered[3], 2);
      chk("order.fifth",  delivered[4], 4);
    end

    do_reset();
    for (int i = 0; i < 254; i++) step(1, 3'd1, 1, 0, 0, 0);
    chk("sat.drop_254", int'(drop_cnt), 254);
    for (int i = 0; i < 46; i++) step(1, 3'd1, 1, 0, 0, 0);
    chk("sat.drop_held", int'(drop_cnt), 255);
    chk("sat.count",     int'(count),    0);
    step(1, 3'd2, 0, 1, 0, 0);
    step(0, 3'd0, 0, 0, 0, 0);
    chk("pre_rst.count", int'(count),       1);
    chk("pre_rst.corr",  int'(corrupt_cnt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.count",     int'(count),       0);
    chk("async_rst.drop_cnt",  int'(drop_cnt),    0);
    chk("async_rst.corr_cnt",  int'(corrupt_cnt), 0);
    chk("async_rst.out_valid", int'(out_valid),   0);
    chk("async_rst.out_msg",   int'(out_msg),     4);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    step(1, 3'd2, 0, 0, 0, 0);
    delivered.delete();
    step(0, 3'd0, 0, 0, 1, 1);
    step(0, 3'd0, 0, 0, 1, 1);
    step(0, 3'd0, 0, 0, 1, 0);
    step(0, 3'd0, 0, 0, 1, 0);
`ifdef ABP_CHAN_DUP_EN
    exp_deliv = 3;
`else
    exp_deliv = 1;
`endif
    n_two = 0;
    foreach (delivered[k]) if (delivered[k] == 2) n_two++;
    chk("dup.deliveries", delivered.size(), exp_deliv);
    chk("dup.all_data10", n_two,            exp_deliv);
    chk("dup.count_end",  int'(count),      0);

    do_reset();
    model_reset();
    model_check("rand.start");
    for (int i = 0; i < 600; i++) begin
      logic       v, d, c, r, u;
      logic [2:0] m;
      v = 1'($urandom_range(0, 3) != 0);
      m = 3'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 7) == 0);
      c = 1'($urandom_range(0, 5) == 0);
      r = 1'($urandom_range(0, 2) != 0);
      u = 1'($urandom_range(0, 3) == 0);
      model_step(v, m, d, c, r, u);
      step(v, m, d, c, r, u);
      model_check($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
